// File: rtl/serial_pkg.sv
// serial_pkg: serial-line state type, line levels and defaults shared by the tx and rx sides
package serial_pkg;
  localparam int SERIAL_DATA_W = 8;
  localparam logic SERIAL_IDLE_LEVEL = 1'b1;
  localparam logic SERIAL_START_LEVEL = 1'b0;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: counts 0..CYCLES-1 while enabled and flags the terminal count
module serial_bit_timer import serial_pkg::*; #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = cnt_w(CYCLES);
  localparam logic [W-1:0] LAST = W'(CYCLES - 1);
  logic [W-1:0] cnt;
  assign tc = en && cnt == LAST;
  // clear wins; the count wraps to zero on the terminal count
  always_ff @(posedge clk)
    if (!reset || clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/serial_tx.sv
// serial_tx: start bit, DATA_W bits LSB first, stop bit; define SERIAL_TX_PARITY_EN for an even-parity bit before stop
module serial_tx import serial_pkg::*; #(
  parameter int DATA_W = SERIAL_DATA_W,
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  localparam int IW = cnt_w(DATA_W);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_W - 1);
`ifdef SERIAL_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif
  tx_state_t state, state_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic [IW-1:0] idx, idx_d;
  logic tc, done_d, tx_d, par;
  logic accept;
  assign accept = in_valid && in_ready;
  serial_bit_timer #(.CYCLES(BIT_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(state == IDLE),
    .en(state != IDLE),
    .tc(tc)
  );
`ifdef SERIAL_TX_PARITY_EN
  // even parity of the word, captured together with it on accept
  always_ff @(posedge clk)
    if (!reset) par <= 1'b0;
    else if (accept) par <= ^in_data;
`else
  assign par = SERIAL_IDLE_LEVEL;
`endif
  // next state, shift register and bit index; tx is derived from the next state so it is registered
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    idx_d = idx;
    done_d = 1'b0;
    case (state)
      IDLE:   if (accept) begin state_d = START; shreg_d = in_data; idx_d = '0; end
      START:  if (tc) state_d = DATA;
      DATA:   if (tc) begin
                shreg_d = shreg >> 1;
                idx_d = idx + 1'b1;
                if (idx == LAST_BIT) state_d = AFTER_DATA;
              end
      PARITY: if (tc) state_d = STOP;
      STOP:   if (tc) begin state_d = IDLE; done_d = 1'b1; end
      default: state_d = IDLE;
    endcase
    tx_d = state_d == START ? SERIAL_START_LEVEL :
           state_d == DATA ? shreg_d[0] :
           state_d == PARITY ? par : SERIAL_IDLE_LEVEL;
  end
  // state register and registered outputs
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      idx <= '0;
      tx <= SERIAL_IDLE_LEVEL;
      in_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      idx <= idx_d;
      tx <= tx_d;
      in_ready <= state_d == IDLE;
      busy <= state_d != IDLE;
      done <= done_d;
    end
endmodule
